mmio_tx_fifo: RTL and testbench

Memory-mapped transmit peripheral that responds to store/load accesses from the single-cycle processor's data-memory port. Stored bytes are buffered in a FIFO and drained on a valid/ready byte stream toward an output consumer, such as a bench monitor or a future UART. It exposes status and control registers so programs can poll occupancy and detect overflow.

---
 rtl/mmio_tx_fifo.sv | 135 +++++++++++++
 tb/tb_mmio_tx_fifo.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mmio_tx_fifo.sv
// mmio_tx_fifo: memory-mapped transmit FIFO for the single-cycle processor.
// Stores to DATA push bytes into a FIFO that drains on a valid/ready byte stream.
// STATUS exposes occupancy, overflow, empty and full. CTRL gates the stream.
//
// Ports:
//   CLK        system clock, rising edge
//   RST        synchronous active-high reset
//   MemWrite   processor store strobe
//   MemRead    processor load strobe
//   Address    processor byte address
//   WriteData  processor store data
//   ReadData   load data, combinational in the same cycle as Address
//   tx_valid   stream byte available (enable && !empty)
//   tx_data    byte at FIFO head
//   tx_ready   consumer accepts byte
//
// Register window (16 bytes at BASE_ADDR, word aligned accesses only):
//   +0x0 DATA   (write-only)   +0x4 STATUS   +0x8 CTRL   +0xC reserved
module mmio_tx_fifo #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
  parameter int unsigned DEPTH     = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          enable_q, enable_d;
  logic [7:0]    mem_q [DEPTH];

  logic       sel_c;
  logic [1:0] offset_c;
  logic       full_c, empty_c;
  logic       pop_c, push_req_c, push_c, ovf_set_c;
  logic       unused_wdata_c;

  // Address decode: inside the window and word aligned.
  assign sel_c    = (Address[31:4] == BASE_ADDR[31:4]) && (Address[1:0] == 2'b00);
  assign offset_c = Address[3:2];

  assign full_c  = (count_q == CW'(DEPTH));
  assign empty_c = (count_q == '0);

  assign tx_valid = enable_q && !empty_c;
  assign tx_data  = mem_q[rd_ptr_q];

  assign pop_c      = tx_valid && tx_ready;
  assign push_req_c = MemWrite && sel_c && (offset_c == OFF_DATA);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_c     = push_req_c && (!full_c || pop_c);
  assign ovf_set_c  = push_req_c && full_c && !pop_c;

  assign unused_wdata_c = ^WriteData[31:8];

  // Next-state for pointers, occupancy and control bits.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    enable_d   = enable_q;

    if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);

    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Setting overflow takes priority over a software clear in the same cycle.
    if (MemWrite && sel_c && (offset_c == OFF_STATUS) && WriteData[2])
      overflow_d = 1'b0;
    if (ovf_set_c)
      overflow_d = 1'b1;

    if (MemWrite && sel_c && (offset_c == OFF_CTRL))
      enable_d = WriteData[0];
  end

  // State registers; a store in the reset cycle is discarded.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      enable_q   <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      enable_q   <= enable_d;
    end
  end

  // Byte storage, intentionally not reset.
  always_ff @(posedge CLK) begin
    if (push_c && !RST)
      mem_q[wr_ptr_q] <= WriteData[7:0];
  end

  // Combinational load path for the single-cycle datapath.
  always_comb begin
    ReadData = 32'h0;
    if (MemRead && sel_c) begin
      case (offset_c)
        OFF_STATUS: ReadData = {16'h0, 8'(count_q), 5'b0, overflow_q, empty_c, full_c};
        OFF_CTRL:   ReadData = {31'h0, enable_q};
        default:    ReadData = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_tx_fifo.sv
// Directed bench for mmio_tx_fifo with a byte scoreboard on the stream side.
module tb_mmio_tx_fifo;

  logic        CLK;
  logic        RST;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb [$];

  mmio_tx_fifo #(.BASE_ADDR(32'h0000_0400), .DEPTH(8)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .MemWrite (MemWrite),
    .MemRead  (MemRead),
    .Address  (Address),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One-cycle store; inputs change 1 time unit after the rising edge.
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    Address   = a;
    WriteData = d;
    @(posedge CLK); #1;
    MemWrite  = 1'b0;
    Address   = 32'h0;
    WriteData = 32'h0;
  endtask

  task automatic push(input logic [7:0] b, input bit accepted);
    if (accepted) sb.push_back(b);
    store(32'h0000_0400, {24'h0, b});
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    MemRead = 1'b1;
    Address = a;
    #1;
    chk(tag, ReadData, exp);
    MemRead = 1'b0;
    Address = 32'h0;
  endtask

  // Wait (bounded) for the scoreboard to empty, then confirm the stream idles.
  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge CLK); #1;
      n++;
    end
    chk({tag, "_left"}, 32'(sb.size()), 32'h0);
    chk({tag, "_valid"}, {31'h0, tx_valid}, 32'h0);
  endtask

  // Stream monitor: every offered byte must be the scoreboard head, which also
  // covers stability during stalls; a handshake retires the head.
  always @(negedge CLK) begin
    if (!RST && tx_valid === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL stream_extra: observed %h expected no byte", tx_data);
      end
      if (sb.size() != 0) begin
        checks++;
        assert (tx_data === sb[0]) else begin
          errors++;
          $error("FAIL stream_data: observed %h expected %h", tx_data, sb[0]);
        end
        if (tx_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    RST = 1'b1; MemWrite = 1'b0; MemRead = 1'b0;
    Address = 32'h0; WriteData = 32'h0; tx_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    // Reset state
    chk("rst_rdata_idle", ReadData, 32'h0);
    rd("rst_status", 32'h0000_0404, 32'h0000_0002);
    rd("rst_ctrl", 32'h0000_0408, 32'h0);
    chk("rst_valid", {31'h0, tx_valid}, 32'h0);

    // Buffer while disabled, then enable and stream
    tx_ready = 1'b1;
    push(8'h41, 1'b1);
    push(8'h42, 1'b1);
    push(8'h43, 1'b1);
    rd("three_status", 32'h0000_0404, 32'h0000_0300);
    rd("data_reads_zero", 32'h0000_0400, 32'h0);
    chk("disabled_valid", {31'h0, tx_valid}, 32'h0);
    store(32'h0000_0408, 32'h1);
    rd("ctrl_on", 32'h0000_0408, 32'h1);
    drain("drain1");
    rd("drain1_status", 32'h0000_0404, 32'h0000_0002);

    // Overflow: ninth byte dropped, sticky flag, then software clear
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) push(8'(8'h10 + i), i < 8);
    rd("ovf_status", 32'h0000_0404, 32'h0000_0805);
    store(32'h0000_0404, 32'h4);
    rd("ovf_cleared", 32'h0000_0404, 32'h0000_0801);
    tx_ready = 1'b1;
    drain("drain2");

    // Full FIFO with simultaneous push and pop
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(8'h20 + i), 1'b1);
    rd("full_status", 32'h0000_0404, 32'h0000_0801);
    tx_ready = 1'b1;
    push(8'h55, 1'b1);
    tx_ready = 1'b0;
    rd("full_pushpop_status", 32'h0000_0404, 32'h0000_0801);
    tx_ready = 1'b1;
    drain("drain3");

    // Back-pressure pattern
    tx_ready = 1'b0;
    push(8'hA0, 1'b1);
    push(8'hA1, 1'b1);
    push(8'hA2, 1'b1);
    tx_ready = 1'b1; @(posedge CLK); #1;
    tx_ready = 1'b0; @(posedge CLK); #1;
    tx_ready = 1'b1; @(posedge CLK); #1;
    tx_ready = 1'b0; @(posedge CLK); #1;
    rd("stall_status", 32'h0000_0404, 32'h0000_0100);
    tx_ready = 1'b1;
    drain("drain4");

    // Disable mid-stream keeps the head byte
    tx_ready = 1'b0;
    push(8'hB0, 1'b1);
    chk("en_valid_on", {31'h0, tx_valid}, 32'h1);
    store(32'h0000_0408, 32'h0);
    chk("en_valid_off", {31'h0, tx_valid}, 32'h0);
    tx_ready = 1'b1;
    @(posedge CLK); #1;
    rd("en_hold_status", 32'h0000_0404, 32'h0000_0100);
    store(32'h0000_0408, 32'h1);
    drain("drain5");

    // Reset mid-operation with a store in the reset cycle
    tx_ready = 1'b0;
    store(32'h0000_0408, 32'h0);
    push(8'h61, 1'b1);
    push(8'h62, 1'b1);
    push(8'h63, 1'b1);
    rd("pre_rst_status", 32'h0000_0404, 32'h0000_0300);
    sb.delete();
    RST = 1'b1;
    store(32'h0000_0400, 32'h99);
    RST = 1'b0;
    rd("post_rst_status", 32'h0000_0404, 32'h0000_0002);
    rd("post_rst_ctrl", 32'h0000_0408, 32'h0);
    chk("post_rst_valid", {31'h0, tx_valid}, 32'h0);

    // Misaligned and unselected accesses have no effect
    store(32'h0000_0402, 32'h77);
    store(32'h0000_0500, 32'h78);
    store(32'h0000_040A, 32'h1);
    rd("misaligned_read", 32'h0000_0406, 32'h0);
    rd("unselected_read", 32'h0000_0504, 32'h0);
    rd("stray_status", 32'h0000_0404, 32'h0000_0002);
    rd("stray_ctrl", 32'h0000_0408, 32'h0);
    rd("reserved_read", 32'h0000_040C, 32'h0);
    tx_ready = 1'b1;
    store(32'h0000_0408, 32'h1);
    repeat (3) @(posedge CLK);
    #1;
    chk("no_stale_valid", {31'h0, tx_valid}, 32'h0);
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
